mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: issues one data-memory request per load/store,
// stalls upstream until ack, and feeds the memory-writeback register.
// Optional access timeout and sticky err_o are enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic        reg_wr_i,
   input  logic        mem_to_reg_i,
   input  logic        mem_wr_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] res_alu_i,
   input  logic [31:0] wr_data_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
`ifdef MEM_ACCESS_TIMEOUT_EN
   output logic        err_o,
`endif
   output logic        reg_wr_wb_o,
   output logic        mem_to_reg_wb_o,
   output logic [4:0]  rd_wb_o,
   output logic [31:0] res_alu_wb_o,
   output logic [31:0] rdata_wb_o
);

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   state_e      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        lat_reg_wr_q, lat_reg_wr_d;
   logic        lat_m2r_q, lat_m2r_d;
   logic [4:0]  lat_rd_q, lat_rd_d;
   logic [31:0] lat_alu_q, lat_alu_d;
   logic        reg_wr_wb_q, reg_wr_wb_d;
   logic        m2r_wb_q, m2r_wb_d;
   logic [4:0]  rd_wb_q, rd_wb_d;
   logic [31:0] res_alu_wb_q, res_alu_wb_d;
   logic [31:0] rdata_wb_q, rdata_wb_d;
   logic        stall;
   logic        mem_op;
   logic        timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   assign timeout = (state_q == S_WAIT) && !dmem_ack_i && (cnt_q == TIMEOUT_LAST);
`else
   assign timeout = 1'b0;
`endif

   assign mem_op = valid_i & (mem_wr_i | mem_to_reg_i);

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lat_reg_wr_d = lat_reg_wr_q;
      lat_m2r_d    = lat_m2r_q;
      lat_rd_d     = lat_rd_q;
      lat_alu_d    = lat_alu_q;
      reg_wr_wb_d  = reg_wr_wb_q;
      m2r_wb_d     = m2r_wb_q;
      rd_wb_d      = rd_wb_q;
      res_alu_wb_d = res_alu_wb_q;
      rdata_wb_d   = rdata_wb_q;
      stall        = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               stall        = 1'b1;
               state_d      = S_WAIT;
               req_d        = 1'b1;
               we_d         = mem_wr_i;
               addr_d       = {res_alu_i[31:2], 2'b00};
               wdata_d      = wr_data_i;
               lat_reg_wr_d = reg_wr_i;
               lat_m2r_d    = mem_to_reg_i;
               lat_rd_d     = rd_i;
               lat_alu_d    = res_alu_i;
               reg_wr_wb_d  = 1'b0;
               m2r_wb_d     = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
               cnt_d        = 8'd0;
`endif
            end else begin
               reg_wr_wb_d  = reg_wr_i & valid_i;
               m2r_wb_d     = mem_to_reg_i;
               rd_wb_d      = rd_i;
               res_alu_wb_d = res_alu_i;
            end
         end

         S_WAIT: begin
            stall = ~dmem_ack_i & ~timeout;
            if (dmem_ack_i) begin
               state_d      = S_IDLE;
               req_d        = 1'b0;
               reg_wr_wb_d  = lat_reg_wr_q & ~we_q;
               m2r_wb_d     = lat_m2r_q;
               rd_wb_d      = lat_rd_q;
               res_alu_wb_d = lat_alu_q;
               if (!we_q) rdata_wb_d = dmem_rdata_i;
            end else if (timeout) begin
               // WB already holds the bubble loaded on entry to WAIT.
               state_d = S_IDLE;
               req_d   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
               err_d   = 1'b1;
`endif
            end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
               cnt_d = cnt_q + 8'd1;
`endif
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         lat_reg_wr_q <= 1'b0;
         lat_m2r_q    <= 1'b0;
         lat_rd_q     <= '0;
         lat_alu_q    <= '0;
         reg_wr_wb_q  <= 1'b0;
         m2r_wb_q     <= 1'b0;
         rd_wb_q      <= '0;
         res_alu_wb_q <= '0;
         rdata_wb_q   <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lat_reg_wr_q <= lat_reg_wr_d;
         lat_m2r_q    <= lat_m2r_d;
         lat_rd_q     <= lat_rd_d;
         lat_alu_q    <= lat_alu_d;
         reg_wr_wb_q  <= reg_wr_wb_d;
         m2r_wb_q     <= m2r_wb_d;
         rd_wb_q      <= rd_wb_d;
         res_alu_wb_q <= res_alu_wb_d;
         rdata_wb_q   <= rdata_wb_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   // Reset must silence stall even while a memory op is presented in IDLE.
   assign stall_o         = stall & ~reset;
   assign dmem_req_o      = req_q;
   assign dmem_we_o       = we_q;
   assign dmem_addr_o     = addr_q;
   assign dmem_wdata_o    = wdata_q;
   assign reg_wr_wb_o     = reg_wr_wb_q;
   assign mem_to_reg_wb_o = m2r_wb_q;
   assign rd_wb_o         = rd_wb_q;
   assign res_alu_wb_o    = res_alu_wb_q;
   assign rdata_wb_o      = rdata_wb_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
   assign err_o           = err_q;
`endif

endmodule
